// File: rtl/verificador_porta_logica.sv
// Vector sequencer that checks an N-input combinational gate against a truth table.
// Walks every input combination, counts mismatches and reports pass/fail with start/done.
module verificador_porta_logica #(
  parameter int unsigned                  N_ENTRADAS = 2,
  parameter logic [2**N_ENTRADAS-1:0]     TABELA     = 4'b1000,
  parameter int unsigned                  ESPERA     = 1
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  iniciar,
  input  logic                  saida_porta,
  output logic [N_ENTRADAS-1:0] entradas,
  output logic                  ocupado,
  output logic                  concluido,
  output logic                  passou,
  output logic [N_ENTRADAS:0]   erros,
  output logic [N_ENTRADAS-1:0] primeiro_erro
);

  localparam logic [1:0] S_OCIOSO  = 2'd0;
  localparam logic [1:0] S_ESPERA  = 2'd1;
  localparam logic [1:0] S_COMPARA = 2'd2;
  localparam logic [1:0] S_FIM     = 2'd3;

  localparam int unsigned CW = (ESPERA > 1) ? $clog2(ESPERA) : 1;

  localparam logic [CW-1:0]         CONT_MAX = CW'(ESPERA - 1);
  localparam logic [CW-1:0]         CONT_UM  = CW'(1);
  localparam logic [N_ENTRADAS-1:0] ENT_UM   = N_ENTRADAS'(1);
  localparam logic [N_ENTRADAS-1:0] ULTIMO   = '1;
  localparam logic [N_ENTRADAS:0]   ERR_UM   = (N_ENTRADAS + 1)'(1);

  logic [1:0]            r_estado;
  logic [CW-1:0]         r_cont;
  logic [N_ENTRADAS-1:0] r_entradas;
  logic                  r_ocupado;
  logic                  r_concluido;
  logic                  r_passou;
  logic [N_ENTRADAS:0]   r_erros;
  logic [N_ENTRADAS-1:0] r_primeiro;
  logic                  w_esperado;

  assign w_esperado = TABELA[r_entradas];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_estado    <= S_OCIOSO;
      r_cont      <= '0;
      r_entradas  <= '0;
      r_ocupado   <= 1'b0;
      r_concluido <= 1'b0;
      r_passou    <= 1'b0;
      r_erros     <= '0;
      r_primeiro  <= '0;
    end else begin
      r_concluido <= 1'b0;
      case (r_estado)
        S_OCIOSO: begin
          if (iniciar) begin
            r_entradas <= '0;
            r_erros    <= '0;
            r_passou   <= 1'b0;
            r_primeiro <= '0;
            r_ocupado  <= 1'b1;
            r_cont     <= '0;
            r_estado   <= S_ESPERA;
          end
        end
        S_ESPERA: begin
          if (r_cont == CONT_MAX) begin
            r_estado <= S_COMPARA;
          end else begin
            r_cont <= r_cont + CONT_UM;
          end
        end
        S_COMPARA: begin
          // Written as if/else so an X on saida_porta falls into the mismatch branch.
          if (saida_porta == w_esperado) begin
            r_erros <= r_erros;
          end else begin
            r_erros <= r_erros + ERR_UM;
            if (r_erros == '0) begin
              r_primeiro <= r_entradas;
            end
          end
          if (r_entradas == ULTIMO) begin
            r_estado <= S_FIM;
          end else begin
            r_entradas <= r_entradas + ENT_UM;
            r_cont     <= '0;
            r_estado   <= S_ESPERA;
          end
        end
        S_FIM: begin
          r_concluido <= 1'b1;
          r_ocupado   <= 1'b0;
          r_passou    <= (r_erros == '0);
          r_estado    <= S_OCIOSO;
        end
        default: r_estado <= S_OCIOSO;
      endcase
    end
  end

  assign entradas      = r_entradas;
  assign ocupado       = r_ocupado;
  assign concluido     = r_concluido;
  assign passou        = r_passou;
  assign erros         = r_erros;
  assign primeiro_erro = r_primeiro;

endmodule

// File: tb/tb_verificador_porta_logica.sv
// Directed bench for verificador_porta_logica: default instance (AND, N=2, ESPERA=1)
// plus a 3-input instance (TABELA=8'h80, ESPERA=3).
module tb_verificador_porta_logica;

  logic       Clock;
  logic       Resetn;
  logic       iniciar_a, iniciar_b;
  logic       saida_a, saida_b;
  logic [1:0] entradas_a;
  logic [2:0] entradas_b;
  logic       ocupado_a, concluido_a, passou_a;
  logic       ocupado_b, concluido_b, passou_b;
  logic [2:0] erros_a;
  logic [3:0] erros_b;
  logic [1:0] primeiro_a;
  logic [2:0] primeiro_b;

  // 0 = AND, 1 = stuck at 0, 2 = NAND
  int modo_a;

  int n_chk;
  int n_err;

  assign saida_a = (modo_a == 0) ? (&entradas_a) :
                   (modo_a == 1) ? 1'b0 : ~(&entradas_a);
  assign saida_b = &entradas_b;

  verificador_porta_logica u_dut_a (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .iniciar       (iniciar_a),
    .saida_porta   (saida_a),
    .entradas      (entradas_a),
    .ocupado       (ocupado_a),
    .concluido     (concluido_a),
    .passou        (passou_a),
    .erros         (erros_a),
    .primeiro_erro (primeiro_a)
  );

  verificador_porta_logica #(
    .N_ENTRADAS (3),
    .TABELA     (8'h80),
    .ESPERA     (3)
  ) u_dut_b (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .iniciar       (iniciar_b),
    .saida_porta   (saida_b),
    .entradas      (entradas_b),
    .ocupado       (ocupado_b),
    .concluido     (concluido_b),
    .passou        (passou_b),
    .erros         (erros_b),
    .primeiro_erro (primeiro_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic passo();
    @(posedge Clock);
    #1;
  endtask

  // Starts dut A; returns edges counted from S until concluido is seen (bounded).
  task automatic roda_a(input bit pulso_meio, output int ciclos, output int n_conc);
    iniciar_a = 1'b1;
    passo();
    iniciar_a = 1'b0;
    ciclos = 0;
    n_conc = 0;
    while (!concluido_a && ciclos < 200) begin
      if (pulso_meio) iniciar_a = (ciclos == 3);
      passo();
      ciclos++;
    end
    iniciar_a = 1'b0;
    if (concluido_a) n_conc++;
    for (int i = 0; i < 4; i++) begin
      passo();
      if (concluido_a) n_conc++;
    end
  endtask

  int ciclos;
  int n_conc;

  initial begin
    n_chk     = 0;
    n_err     = 0;
    modo_a    = 0;
    Resetn    = 1'b0;
    iniciar_a = 1'b1;
    iniciar_b = 1'b1;

    // 1: reset with iniciar high
    passo();
    passo();
    verifica("reset_outs_a", {entradas_a, ocupado_a, concluido_a, passou_a, erros_a, primeiro_a}, 0);
    verifica("reset_outs_b", {entradas_b, ocupado_b, concluido_b, passou_b, erros_b, primeiro_b}, 0);
    Resetn    = 1'b1;
    iniciar_a = 1'b0;
    iniciar_b = 1'b0;
    passo();
    passo();
    verifica("idle_after_reset", {ocupado_a, ocupado_b}, 0);

    // 2: correct AND, with vector stepping
    iniciar_a = 1'b1;
    passo();
    iniciar_a = 1'b0;
    verifica("ocupado_at_s", ocupado_a, 1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) passo();
      verifica($sformatf("step_k%0d", k), entradas_a, (k < 8) ? (k / 2) : 3);
      verifica($sformatf("conc_low_k%0d", k), concluido_a, 0);
    end
    passo();
    verifica("conc_s9", concluido_a, 1);
    verifica("ocupado_s9", ocupado_a, 0);
    verifica("and_erros", erros_a, 0);
    verifica("and_passou", passou_a, 1);
    verifica("entradas_hold", entradas_a, 3);
    passo();
    verifica("conc_s10", concluido_a, 0);

    // 3: stuck at 0
    modo_a = 1;
    roda_a(1'b0, ciclos, n_conc);
    verifica("st0_latency", ciclos, 9);
    verifica("st0_erros", erros_a, 1);
    verifica("st0_primeiro", primeiro_a, 3);
    verifica("st0_passou", passou_a, 0);
    verifica("st0_conc_once", n_conc, 1);

    // 4: NAND
    modo_a = 2;
    roda_a(1'b0, ciclos, n_conc);
    verifica("nand_erros", erros_a, 4);
    verifica("nand_primeiro", primeiro_a, 0);
    verifica("nand_passou", passou_a, 0);

    // 5: reset mid-run while entradas == 2
    modo_a = 0;
    iniciar_a = 1'b1;
    passo();
    iniciar_a = 1'b0;
    ciclos = 0;
    while (entradas_a != 2'b10 && ciclos < 50) begin
      passo();
      ciclos++;
    end
    verifica("mid_reach_v2", entradas_a, 2);
    Resetn = 1'b0;
    passo();
    Resetn = 1'b1;
    verifica("midrst_outs", {entradas_a, ocupado_a, concluido_a, passou_a, erros_a, primeiro_a}, 0);
    n_conc = 0;
    for (int i = 0; i < 15; i++) begin
      passo();
      if (concluido_a) n_conc++;
    end
    verifica("midrst_no_conc", n_conc, 0);
    roda_a(1'b0, ciclos, n_conc);
    verifica("fresh_latency", ciclos, 9);
    verifica("fresh_passou", passou_a, 1);

    // 6: mid-run pulse ignored, then held iniciar restarts right after FIM
    roda_a(1'b1, ciclos, n_conc);
    verifica("pulse_latency", ciclos, 9);
    verifica("pulse_conc_once", n_conc, 1);
    iniciar_a = 1'b1;
    passo();
    ciclos = 0;
    while (!concluido_a && ciclos < 200) begin
      passo();
      ciclos++;
    end
    verifica("hold_latency1", ciclos, 9);
    passo();
    verifica("hold_restart", {ocupado_a, concluido_a, entradas_a}, {1'b1, 1'b0, 2'b00});
    iniciar_a = 1'b0;
    ciclos = 0;
    while (!concluido_a && ciclos < 200) begin
      passo();
      ciclos++;
    end
    verifica("hold_latency2", ciclos, 9);
    verifica("hold_passou", passou_a, 1);

    // N=3, ESPERA=3
    iniciar_b = 1'b1;
    passo();
    iniciar_b = 1'b0;
    ciclos = 0;
    while (!concluido_b && ciclos < 400) begin
      passo();
      ciclos++;
    end
    verifica("b_latency", ciclos, 33);
    verifica("b_passou", passou_b, 1);
    verifica("b_erros", erros_b, 0);
    verifica("b_entradas", entradas_b, 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
